stream_down_converter_32to8: RTL and testbench

- Sits directly downstream of the TX anti-underflow buffer.
- Consumes its 32-bit packet stream (data, last_be, error) and serialises each word into bytes for the 8-bit MAC/PHY TX path.
- Honours last_be on the final word so that only valid bytes are emitted, and maps per-byte error flags onto the byte stream.
- Full throughput: one byte per cycle, with no bubble between consecutive words.

---
 rtl/stream_down_converter_32to8_if.sv | 39 +++
 rtl/stream_down_converter_32to8.sv | 93 +++++++++
 tb/tb_stream_down_converter_32to8.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_down_converter_32to8_if.sv
// ---------------------------------------------------------------------------
// stream_down_converter_32to8_if
// Valid/ready packet stream bundle used on both sides of the 32->8 down
// converter. The same bundle carries the 32-bit word stream (DW=32) and the
// 8-bit byte stream (DW=8).
//
// Signals:
//   valid    producer has a beat
//   ready    consumer accepts the beat (transfer on valid & ready)
//   first    beat is the first of a packet
//   last     beat is the last of a packet
//   data     payload, byte lane 0 in [7:0]
//   last_be  one-hot marker of the final valid byte lane on a last beat
//   error    per-lane error flags
// Modports: master drives the beat, slave drives ready.
// ---------------------------------------------------------------------------
interface stream_down_converter_32to8_if #(
    parameter int DW = 32
);
    localparam int NB = DW / 8;

    logic          valid;
    logic          ready;
    logic          first;
    logic          last;
    logic [DW-1:0] data;
    logic [NB-1:0] last_be;
    logic [NB-1:0] error;

    modport master (
        output valid, first, last, data, last_be, error,
        input  ready
    );

    modport slave (
        input  valid, first, last, data, last_be, error,
        output ready
    );
endinterface

// File: rtl/stream_down_converter_32to8.sv
// ---------------------------------------------------------------------------
// stream_down_converter_32to8
// Serialises a 32-bit packet stream (from the TX anti-underflow buffer) into
// bytes for the 8-bit MAC/PHY TX path, lane 0 first. On a last word only the
// lanes up to the lowest set bit of last_be are emitted; per-lane error flags
// follow their bytes. One byte per cycle with no bubble between words.
//
// Ports:
//   sys_clk  system clock, rising edge
//   sys_rst  synchronous reset, active low
//   sink     32-bit word stream in  (slave side,  DW = SINK_DW)
//   source   8-bit byte stream out  (master side, DW = 8)
// ---------------------------------------------------------------------------
module stream_down_converter_32to8 #(
    parameter int SINK_DW = 32
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst,
    stream_down_converter_32to8_if.slave   sink,
    stream_down_converter_32to8_if.master  source
);
    localparam int N_BYTES = SINK_DW / 8;
    localparam int IW      = $clog2(N_BYTES);
    localparam logic [IW-1:0] LAST_LANE = IW'(N_BYTES - 1);

    logic               wvalid;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      end_lane;
    logic               first_r;
    logic               last_r;
    logic [SINK_DW-1:0] data_r;
    logic [N_BYTES-1:0] error_r;

    logic [IW-1:0]      sink_end_lane;
    logic               final_beat;
    logic               sink_accept;
    logic               byte_accept;

    // Final lane of the incoming word. Scanning from the top down lets the
    // lowest set bit of last_be win; an empty last_be keeps the whole word.
    always_comb begin
        sink_end_lane = LAST_LANE;
        if (sink.last) begin
            for (int i = N_BYTES - 1; i >= 0; i--) begin
                if (sink.last_be[i]) begin
                    sink_end_lane = IW'(i);
                end
            end
        end
    end

    assign final_beat  = (idx == end_lane);
    // Held low during reset so no word is taken while the datapath clears.
    assign sink.ready  = sys_rst & (~wvalid | (source.ready & final_beat));
    assign sink_accept = sink.valid & sink.ready;
    assign byte_accept = wvalid & source.ready;

    assign source.valid   = wvalid;
    assign source.data    = data_r[{idx, 3'b000} +: 8];
    assign source.error   = error_r[idx];
    assign source.first   = first_r & (idx == '0);
    assign source.last    = last_r & final_beat;
    assign source.last_be = source.last;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            wvalid   <= 1'b0;
            idx      <= '0;
            end_lane <= '0;
            first_r  <= 1'b0;
            last_r   <= 1'b0;
            data_r   <= '0;
            error_r  <= '0;
        end else if (sink_accept) begin
            // Also covers the final byte leaving on this same edge, which is
            // what chains words without a gap.
            wvalid   <= 1'b1;
            idx      <= '0;
            end_lane <= sink_end_lane;
            first_r  <= sink.first;
            last_r   <= sink.last;
            data_r   <= sink.data;
            error_r  <= sink.error;
        end else if (byte_accept) begin
            if (final_beat) begin
                wvalid <= 1'b0;
                idx    <= '0;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end
endmodule

// File: tb/tb_stream_down_converter_32to8.sv
module tb_stream_down_converter_32to8;
    logic sys_clk = 1'b0;
    logic sys_rst = 1'b0;

    always #5 sys_clk = ~sys_clk;

    stream_down_converter_32to8_if #(.DW(32)) sink_if ();
    stream_down_converter_32to8_if #(.DW(8))  src_if ();

    stream_down_converter_32to8 #(.SINK_DW(32)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .sink    (sink_if),
        .source  (src_if)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_count   = 0;

    // expected byte: {first, last, error, data}
    logic [10:0] sb[$];
    int          acc_cyc[$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] d, input logic f, input logic l,
                             input logic [3:0] be, input logic [3:0] e);
        int last_lane;
        last_lane = 3;
        if (l) begin
            if (be[0])      last_lane = 0;
            else if (be[1]) last_lane = 1;
            else if (be[2]) last_lane = 2;
            else            last_lane = 3;
        end
        for (int i = 0; i <= last_lane; i++) begin
            sb.push_back({f && (i == 0), l && (i == last_lane), e[i], d[8*i +: 8]});
        end
    endtask

    task automatic put_word(input logic [31:0] d, input logic f, input logic l,
                            input logic [3:0] be, input logic [3:0] e);
        int   n;
        logic acc;
        push_word(d, f, l, be, e);
        sink_if.valid   = 1'b1;
        sink_if.data    = d;
        sink_if.first   = f;
        sink_if.last    = l;
        sink_if.last_be = be;
        sink_if.error   = e;
        n   = 0;
        acc = 1'b0;
        while (!acc) begin
            @(negedge sys_clk);
            acc = sink_if.ready;
            @(posedge sys_clk);
            #1;
            n++;
            if (!acc && n > 100) begin
                chk("sink_accept_timeout", 32'(acc), 32'(1));
                break;
            end
        end
        sink_if.valid = 1'b0;
    endtask

    task automatic wait_bytes(input int target);
        int n;
        n = 0;
        while (acc_count < target && n < 200) begin
            @(posedge sys_clk);
            n++;
        end
        chk("byte_wait", 32'(acc_count >= target), 32'(1));
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(posedge sys_clk);
            n++;
        end
        chk({tag, "_drain"}, 32'(sb.size()), 32'(0));
        @(negedge sys_clk);
        chk({tag, "_idle_valid"}, 32'(src_if.valid), 32'(0));
    endtask

    // Output monitor: byte transfers against the scoreboard, and hold
    // stability while the consumer stalls.
    logic       prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b0;
    logic       prev_f = 1'b0, prev_l = 1'b0, prev_e = 1'b0;
    logic [7:0] prev_d = 8'h00;

    always @(negedge sys_clk) begin
        logic [10:0] exp;
        if (sys_rst && prev_rst && prev_v && !prev_r) begin
            chk("hold_valid", 32'(src_if.valid), 32'(1));
            chk("hold_data",  32'(src_if.data),  32'(prev_d));
            chk("hold_first", 32'(src_if.first), 32'(prev_f));
            chk("hold_last",  32'(src_if.last),  32'(prev_l));
            chk("hold_error", 32'(src_if.error), 32'(prev_e));
        end
        if (sys_rst && src_if.valid && src_if.ready) begin
            chk("byte_expected", 32'(sb.size() != 0), 32'(1));
            if (sb.size() != 0) begin
                exp = sb.pop_front();
                chk("byte_data",    32'(src_if.data),    32'(exp[7:0]));
                chk("byte_error",   32'(src_if.error),   32'(exp[8]));
                chk("byte_last",    32'(src_if.last),    32'(exp[9]));
                chk("byte_last_be", 32'(src_if.last_be), 32'(exp[9]));
                chk("byte_first",   32'(src_if.first),   32'(exp[10]));
            end
            acc_count = acc_count + 1;
            acc_cyc.push_back(cyc);
        end
        prev_v   = src_if.valid;
        prev_r   = src_if.ready;
        prev_rst = sys_rst;
        prev_d   = src_if.data;
        prev_f   = src_if.first;
        prev_l   = src_if.last;
        prev_e   = src_if.error[0];
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int         sent;
        int         base;

        sink_if.valid   = 1'b0;
        sink_if.first   = 1'b0;
        sink_if.last    = 1'b0;
        sink_if.data    = '0;
        sink_if.last_be = '0;
        sink_if.error   = '0;
        src_if.ready    = 1'b0;
        sys_rst         = 1'b0;

        // reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_src_valid",  32'(src_if.valid),   32'(0));
        chk("rst_sink_ready", 32'(sink_if.ready),  32'(0));
        chk("rst_src_data",   32'(src_if.data),    32'(0));
        chk("rst_src_first",  32'(src_if.first),   32'(0));
        chk("rst_src_last",   32'(src_if.last),    32'(0));
        chk("rst_src_last_be",32'(src_if.last_be), 32'(0));
        chk("rst_src_error",  32'(src_if.error),   32'(0));
        @(posedge sys_clk);
        #1 sys_rst = 1'b1;
        @(negedge sys_clk);
        chk("rel_sink_ready", 32'(sink_if.ready), 32'(1));
        chk("rel_src_valid",  32'(src_if.valid),  32'(0));
        @(posedge sys_clk);
        #1;

        // single 4-byte packet, sink_ready only on the final byte
        src_if.ready = 1'b1;
        put_word(32'h44332211, 1'b1, 1'b1, 4'b1000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk);
            chk("t1_src_valid",  32'(src_if.valid),  32'(1));
            chk("t1_sink_ready", 32'(sink_if.ready), 32'(k == 3));
        end
        wait_drain("t1");

        // back-to-back 3-word packet truncated to 10 bytes
        @(posedge sys_clk);
        #1;
        acc_cyc.delete();
        put_word(32'h03020100, 1'b1, 1'b0, 4'b0010, 4'b0000);
        put_word(32'h07060504, 1'b0, 1'b0, 4'b0010, 4'b0000);
        put_word(32'h0B0A0908, 1'b0, 1'b1, 4'b0010, 4'b0000);
        wait_drain("t2");
        chk("t2_byte_count", 32'(acc_cyc.size()), 32'(10));
        if (acc_cyc.size() == 10) begin
            chk("t2_no_bubble", 32'(acc_cyc[9] - acc_cyc[0]), 32'(9));
        end

        // backpressure 1,0,0,1,...
        @(posedge sys_clk);
        #1;
        src_if.ready = 1'b1;
        put_word(32'hDDCCBBAA, 1'b1, 1'b1, 4'b1000, 4'b0000);
        pat  = 10'b1001001001;
        sent = 0;
        for (int k = 0; k < 10; k++) begin
            src_if.ready = pat[k];
            @(negedge sys_clk);
            chk("t3_sink_ready", 32'(sink_if.ready), 32'(pat[k] && sent == 3));
            if (pat[k]) sent++;
            @(posedge sys_clk);
            #1;
        end
        src_if.ready = 1'b1;
        wait_drain("t3");

        // error mapping on a non-last word (last_be ignored)
        @(posedge sys_clk);
        #1;
        put_word(32'h00000000, 1'b1, 1'b0, 4'b0001, 4'b0100);
        wait_drain("t4");

        // single-byte packet carrying first and last
        @(posedge sys_clk);
        #1;
        put_word(32'hEEDDCCA5, 1'b1, 1'b1, 4'b0001, 4'b0011);
        wait_drain("t5a");

        // last with empty last_be: whole word
        @(posedge sys_clk);
        #1;
        put_word(32'h88776655, 1'b1, 1'b1, 4'b0000, 4'b1000);
        wait_drain("t5b");

        // reset after the second byte of a word
        @(posedge sys_clk);
        #1;
        base = acc_count;
        put_word(32'hCAFEF00D, 1'b1, 1'b1, 4'b1000, 4'b0000);
        wait_bytes(base + 2);
        #1;
        sys_rst      = 1'b0;
        src_if.ready = 1'b0;
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("t6_rst_src_valid",  32'(src_if.valid),  32'(0));
        chk("t6_rst_sink_ready", 32'(sink_if.ready), 32'(0));
        chk("t6_rst_src_data",   32'(src_if.data),   32'(0));
        chk("t6_bytes_dropped",  32'(sb.size()),     32'(2));
        sb.delete();
        @(posedge sys_clk);
        #1;
        sys_rst      = 1'b1;
        src_if.ready = 1'b1;
        @(negedge sys_clk);
        chk("t6_rel_sink_ready", 32'(sink_if.ready), 32'(1));
        chk("t6_rel_src_valid",  32'(src_if.valid),  32'(0));
        @(posedge sys_clk);
        #1;
        put_word(32'h04030201, 1'b1, 1'b1, 4'b1000, 4'b0000);
        wait_drain("t6");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
